// File: rtl/gpu_bg_block_sequencer.sv
// gpu_bg_block_sequencer
// Sequences DDR traffic for the backend's 16-pixel background cache line. On a block
// transition or primitive-end flush it writes back the dirty line and/or reads the next
// line, stalls the backend while traffic is in flight, and hands the read line back as a
// one-cycle import strobe.
//
// Ports:
//   clk, i_nrst                 clock, asynchronous active-low reset
//   i_PixelBlockTransition      bit1 leave block (save+load), bit0 first block (load only)
//   i_loadAdr / i_saveAdr       block being entered / left
//   i_exportedBGBlock/MSK       dirty line and per-pixel dirty mask
//   i_needLoad                  line must be read before drawing
//   i_flushReq                  primitive done, write back line
//   o_flushDone/ClearMask       one-cycle flush completion pulses
//   o_pausePipeline             registered stall to backend
//   o_importBGBlockSingleClock  one-cycle import strobe, o_importedBGBlock data
//   o_mem*/i_mem*               DDR command/read-data interface
//   o_saveCount/o_loadCount     saturating statistics
//   o_errOverrun                sticky: event arrived while busy
//
// Build option: GPU_BGSEQ_SAME_BLOCK_BYPASS_EN skips the load when a bit1 transition
// re-enters the block it is leaving.
module gpu_bg_block_sequencer #(
   parameter int unsigned ADR_W = 15,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             i_nrst,
   input  logic [1:0]       i_PixelBlockTransition,
   input  logic [ADR_W-1:0] i_loadAdr,
   input  logic [ADR_W-1:0] i_saveAdr,
   input  logic [255:0]     i_exportedBGBlock,
   input  logic [15:0]      i_exportedMSKBGBlock,
   input  logic             i_needLoad,
   input  logic             i_flushReq,
   output logic             o_flushDone,
   output logic             o_flushClearMask,
   output logic             o_pausePipeline,
   output logic             o_importBGBlockSingleClock,
   output logic [255:0]     o_importedBGBlock,
   output logic             o_memCmdValid,
   input  logic             i_memCmdReady,
   output logic             o_memCmdWrite,
   output logic [ADR_W-1:0] o_memAdr,
   output logic [255:0]     o_memWriteData,
   output logic [15:0]      o_memWriteMask,
   input  logic             i_memReadValid,
   input  logic [255:0]     i_memReadData,
   output logic [CNT_W-1:0] o_saveCount,
   output logic [CNT_W-1:0] o_loadCount,
   output logic             o_errOverrun
);

   typedef enum logic [2:0] {
      StIdle, StSave, StLoad, StLoadWait, StFlushSave, StFlushDone
   } state_e;

   state_e           state_q, state_d;
   logic [ADR_W-1:0] save_adr_q, save_adr_d, load_adr_q, load_adr_d;
   logic [255:0]     blk_q, blk_d, imp_q, imp_d;
   logic [15:0]      msk_q, msk_d;
   logic             need_load_q, need_load_d;
   logic             flush_pend_q, flush_pend_d;
   logic             pause_q, pause_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] save_cnt_q, save_cnt_d, load_cnt_q, load_cnt_d;

   logic same_blk, trans_need, flush_ev, cmd_done, write_st, import_hit, busy_ev;

`ifdef GPU_BGSEQ_SAME_BLOCK_BYPASS_EN
   assign same_blk = (i_loadAdr == i_saveAdr);
`else
   assign same_blk = 1'b0;
`endif

   // Re-entering the same block leaves the backend line valid, so no load is needed.
   assign trans_need = i_needLoad & ~(i_PixelBlockTransition[1] & same_blk);
   assign flush_ev   = i_flushReq | flush_pend_q;
   assign write_st   = (state_q == StSave) || (state_q == StFlushSave);
   assign cmd_done   = o_memCmdValid & i_memCmdReady;
   assign import_hit = (state_q == StLoadWait) & i_memReadValid;
   assign busy_ev    = (state_q != StIdle) & ((|i_PixelBlockTransition) | i_flushReq);

   always_comb begin
      state_d      = state_q;
      save_adr_d   = save_adr_q;
      load_adr_d   = load_adr_q;
      blk_d        = blk_q;
      msk_d        = msk_q;
      need_load_d  = need_load_q;
      flush_pend_d = flush_pend_q;
      imp_d        = imp_q;
      save_cnt_d   = save_cnt_q;
      load_cnt_d   = load_cnt_q;
      err_d        = err_q | busy_ev;

      unique case (state_q)
         StIdle: begin
            // Capture now: the backend clears its mask on the next cycle.
            if ((|i_PixelBlockTransition) || flush_ev) begin
               save_adr_d  = i_saveAdr;
               load_adr_d  = i_loadAdr;
               blk_d       = i_exportedBGBlock;
               msk_d       = i_exportedMSKBGBlock;
               need_load_d = trans_need;
            end
            if (i_PixelBlockTransition[1] && ((|i_exportedMSKBGBlock) || trans_need)) begin
               state_d      = (|i_exportedMSKBGBlock) ? StSave : StLoad;
               flush_pend_d = flush_ev;
            end else if (i_PixelBlockTransition[0] && i_needLoad) begin
               state_d      = StLoad;
               flush_pend_d = flush_ev;
            end else if (flush_ev) begin
               state_d      = (|i_exportedMSKBGBlock) ? StFlushSave : StFlushDone;
               flush_pend_d = 1'b0;
            end
         end
         StSave: begin
            if (cmd_done) begin
               save_cnt_d = (save_cnt_q == '1) ? save_cnt_q : save_cnt_q + CNT_W'(1);
               state_d    = need_load_q ? StLoad : StIdle;
            end
         end
         StLoad: begin
            if (cmd_done) begin
               load_cnt_d = (load_cnt_q == '1) ? load_cnt_q : load_cnt_q + CNT_W'(1);
               state_d    = StLoadWait;
            end
         end
         StLoadWait: begin
            if (i_memReadValid) begin
               imp_d   = i_memReadData;
               state_d = StIdle;
            end
         end
         StFlushSave: begin
            if (cmd_done) begin
               save_cnt_d = (save_cnt_q == '1) ? save_cnt_q : save_cnt_q + CNT_W'(1);
               state_d    = StFlushDone;
            end
         end
         StFlushDone: state_d = StIdle;
         default:     state_d = StIdle;
      endcase

      // A pending flush keeps the stall up through its one IDLE turnaround cycle.
      pause_d = (state_d != StIdle) || flush_pend_d;
   end

   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q      <= StIdle;
         save_adr_q   <= '0;
         load_adr_q   <= '0;
         blk_q        <= '0;
         msk_q        <= '0;
         need_load_q  <= 1'b0;
         flush_pend_q <= 1'b0;
         imp_q        <= '0;
         save_cnt_q   <= '0;
         load_cnt_q   <= '0;
         pause_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         save_adr_q   <= save_adr_d;
         load_adr_q   <= load_adr_d;
         blk_q        <= blk_d;
         msk_q        <= msk_d;
         need_load_q  <= need_load_d;
         flush_pend_q <= flush_pend_d;
         imp_q        <= imp_d;
         save_cnt_q   <= save_cnt_d;
         load_cnt_q   <= load_cnt_d;
         pause_q      <= pause_d;
         err_q        <= err_d;
      end
   end

   // Command outputs decode from state only, so ready never reaches valid combinationally.
   assign o_memCmdValid  = write_st || (state_q == StLoad);
   assign o_memCmdWrite  = write_st;
   assign o_memAdr       = write_st ? save_adr_q : ((state_q == StLoad) ? load_adr_q : '0);
   assign o_memWriteData = write_st ? blk_q : '0;
   assign o_memWriteMask = write_st ? msk_q : '0;

   assign o_importBGBlockSingleClock = import_hit;
   assign o_importedBGBlock          = import_hit ? i_memReadData : imp_q;
   assign o_flushDone                = (state_q == StFlushDone);
   assign o_flushClearMask           = (state_q == StFlushDone);
   assign o_pausePipeline            = pause_q;
   assign o_saveCount                = save_cnt_q;
   assign o_loadCount                = load_cnt_q;
   assign o_errOverrun               = err_q;

endmodule

// File: tb/tb_gpu_bg_block_sequencer.sv
module tb_gpu_bg_block_sequencer;

   localparam int ADR_W = 15;
   localparam int CNT_W = 4;  // narrow so saturation is reached quickly
   localparam int CntMax = (1 << CNT_W) - 1;

`ifdef GPU_BGSEQ_SAME_BLOCK_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             i_nrst;
   logic [1:0]       i_PixelBlockTransition;
   logic [ADR_W-1:0] i_loadAdr, i_saveAdr;
   logic [255:0]     i_exportedBGBlock;
   logic [15:0]      i_exportedMSKBGBlock;
   logic             i_needLoad, i_flushReq;
   logic             o_flushDone, o_flushClearMask, o_pausePipeline;
   logic             o_importBGBlockSingleClock;
   logic [255:0]     o_importedBGBlock;
   logic             o_memCmdValid, i_memCmdReady, o_memCmdWrite;
   logic [ADR_W-1:0] o_memAdr;
   logic [255:0]     o_memWriteData;
   logic [15:0]      o_memWriteMask;
   logic             i_memReadValid;
   logic [255:0]     i_memReadData;
   logic [CNT_W-1:0] o_saveCount, o_loadCount;
   logic             o_errOverrun;

   always #5 clk = ~clk;

   gpu_bg_block_sequencer #(.ADR_W(ADR_W), .CNT_W(CNT_W)) dut (
      .clk                        (clk),
      .i_nrst                     (i_nrst),
      .i_PixelBlockTransition     (i_PixelBlockTransition),
      .i_loadAdr                  (i_loadAdr),
      .i_saveAdr                  (i_saveAdr),
      .i_exportedBGBlock          (i_exportedBGBlock),
      .i_exportedMSKBGBlock       (i_exportedMSKBGBlock),
      .i_needLoad                 (i_needLoad),
      .i_flushReq                 (i_flushReq),
      .o_flushDone                (o_flushDone),
      .o_flushClearMask           (o_flushClearMask),
      .o_pausePipeline            (o_pausePipeline),
      .o_importBGBlockSingleClock (o_importBGBlockSingleClock),
      .o_importedBGBlock          (o_importedBGBlock),
      .o_memCmdValid              (o_memCmdValid),
      .i_memCmdReady              (i_memCmdReady),
      .o_memCmdWrite              (o_memCmdWrite),
      .o_memAdr                   (o_memAdr),
      .o_memWriteData             (o_memWriteData),
      .o_memWriteMask             (o_memWriteMask),
      .i_memReadValid             (i_memReadValid),
      .i_memReadData              (i_memReadData),
      .o_saveCount                (o_saveCount),
      .o_loadCount                (o_loadCount),
      .o_errOverrun               (o_errOverrun)
   );

   typedef struct {
      logic [1:0]       trans;
      logic [ADR_W-1:0] sa;
      logic [ADR_W-1:0] la;
      logic [15:0]      msk;
      bit               need;
      bit               flush;
      logic [255:0]     blk;
      logic [255:0]     rdata;
      int               rdy;   // cycles of ready-low before accept
      int               lat;   // cycles from read accept to read data
      int               ew;    // expected writes
      int               er;    // expected reads (= imports)
      bit               ef;    // expected flush completion
   } vec_t;

   int errors = 0;
   int checks = 0;
   int save_m = 0;
   int load_m = 0;

   function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Reference: what DDR traffic and flush completion one event should produce.
   function automatic vec_t model(input vec_t v);
      bit tw, tr, byp;
      byp = Byp && v.trans[1] && (v.la == v.sa);
      tw = 1'b0;
      tr = 1'b0;
      if (v.trans[1]) begin
         tw = (v.msk != 0);
         tr = v.need && !byp;
      end else if (v.trans[0]) begin
         tr = v.need;
      end
      // A flush alongside real transition work finds the mask already cleared.
      v.ew = int'(tw) + int'(v.flush && !(tw || tr) && (v.msk != 0));
      v.er = int'(tr);
      v.ef = v.flush;
      return v;
   endfunction

   task automatic idle_inputs();
      i_PixelBlockTransition = '0;
      i_flushReq             = 1'b0;
      i_exportedMSKBGBlock   = '0;
      i_memCmdReady          = 1'b0;
      i_memReadValid         = 1'b0;
   endtask

   task automatic run_event(input vec_t v, input string nm);
      int cmd_wait, rd_cd, n_w, n_r, n_imp, n_fd, n_cm, fd_cyc, pause_cyc;
      logic [ADR_W-1:0] w_adr, r_adr;
      logic [15:0] w_msk;
      logic [255:0] w_dat, imp_dat;
      logic [ADR_W+272:0] prev_cmd;
      bit prev_pend, unstable, done, pause_at0;
      cmd_wait = 0; rd_cd = -1; n_w = 0; n_r = 0; n_imp = 0; n_fd = 0; n_cm = 0;
      fd_cyc = -1; pause_cyc = 0; prev_pend = 0; unstable = 0; done = 0;
      w_adr = '0; r_adr = '0; w_msk = '0; w_dat = '0; imp_dat = '0; prev_cmd = '0;

      @(negedge clk);
      i_PixelBlockTransition = v.trans;
      i_saveAdr              = v.sa;
      i_loadAdr              = v.la;
      i_exportedBGBlock      = v.blk;
      i_exportedMSKBGBlock   = v.msk;
      i_needLoad             = v.need;
      i_flushReq             = v.flush;
      #1 pause_at0 = o_pausePipeline;

      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(negedge clk);
         idle_inputs();
         if (o_memCmdValid) begin
            i_memCmdReady = (cmd_wait >= v.rdy);
            cmd_wait++;
         end
         if (rd_cd == 0) begin
            i_memReadValid = 1'b1;
            i_memReadData  = v.rdata;
         end
         if (rd_cd >= 0) rd_cd--;
         #1;
         if (o_pausePipeline) pause_cyc++;
         if (o_memCmdValid) begin
            if (!o_pausePipeline) unstable = 1;
            if (prev_pend &&
                ({o_memCmdWrite, o_memAdr, o_memWriteMask, o_memWriteData} != prev_cmd))
               unstable = 1;
            if (i_memCmdReady) begin
               cmd_wait  = 0;
               prev_pend = 0;
               if (o_memCmdWrite) begin
                  n_w++; w_adr = o_memAdr; w_msk = o_memWriteMask; w_dat = o_memWriteData;
               end else begin
                  n_r++; r_adr = o_memAdr; rd_cd = v.lat;
               end
            end else begin
               prev_pend = 1;
               prev_cmd  = {o_memCmdWrite, o_memAdr, o_memWriteMask, o_memWriteData};
            end
         end
         if (o_importBGBlockSingleClock) begin
            n_imp++;
            imp_dat = o_importedBGBlock;
         end
         if (o_flushDone) begin
            n_fd++;
            if (fd_cyc < 0) fd_cyc = cyc;
         end
         if (o_flushClearMask) n_cm++;
         if (!o_pausePipeline && !o_memCmdValid && rd_cd < 0) done = 1;
      end

      chk({nm, " done_in_budget"}, done, 1'b1);
      chk({nm, " pause_event_cycle"}, pause_at0, 1'b0);
      chk({nm, " pause_rose"}, pause_cyc > 0, (v.ew + v.er > 0) || v.ef);
      chk({nm, " cmd_stable"}, unstable, 1'b0);
      chk({nm, " writes"}, n_w, v.ew);
      if (v.ew > 0) begin
         chk({nm, " write_adr"}, w_adr, v.sa);
         chk({nm, " write_mask"}, w_msk, v.msk);
         chk({nm, " write_data"}, w_dat, v.blk);
      end
      chk({nm, " reads"}, n_r, v.er);
      chk({nm, " imports"}, n_imp, v.er);
      if (v.er > 0) begin
         chk({nm, " read_adr"}, r_adr, v.la);
         chk({nm, " import_data"}, imp_dat, v.rdata);
         chk({nm, " import_held"}, o_importedBGBlock, v.rdata);
      end
      chk({nm, " flush_done"}, n_fd, int'(v.ef));
      chk({nm, " flush_clear"}, n_cm, int'(v.ef));
      if (v.ef && v.ew == 0 && v.er == 0) chk({nm, " flush_done_cycle"}, fd_cyc, 1);
      save_m = (save_m + v.ew > CntMax) ? CntMax : save_m + v.ew;
      load_m = (load_m + v.er > CntMax) ? CntMax : load_m + v.er;
      chk({nm, " save_count"}, o_saveCount, save_m);
      chk({nm, " load_count"}, o_loadCount, load_m);
   endtask

   vec_t tbl[10];
   vec_t rv;
   bit   bad, any_valid;

   initial begin
      // trans, sa, la, msk, need, flush, blk, rdata, rdy, lat, ew, er, ef
      tbl[0] = '{2'd2, 15'h0123, 15'h0124, 16'h00F0, 1, 0, {8{32'h1111_2222}}, {32{8'hA5}},
                 3, 5, 1, 1, 0};
      tbl[1] = '{2'd2, 15'h0010, 15'h0011, 16'h0000, 0, 0, {8{32'h3333_4444}}, '0,
                 0, 0, 0, 0, 0};
      tbl[2] = '{2'd0, 15'h0456, 15'h0000, 16'h8001, 0, 1, {8{32'hDEAD_BEEF}}, '0,
                 2, 0, 1, 0, 1};
      tbl[3] = '{2'd0, 15'h0456, 15'h0000, 16'h0000, 0, 1, {8{32'h5555_6666}}, '0,
                 0, 0, 0, 0, 1};
      tbl[4] = '{2'd1, 15'h0001, 15'h7FFF, 16'h0F00, 1, 0, {8{32'h7777_8888}}, {8{32'hCAFE_F00D}},
                 1, 2, 0, 1, 0};
      tbl[5] = '{2'd3, 15'h0321, 15'h0322, 16'h0001, 0, 0, {8{32'h9999_AAAA}}, '0,
                 0, 0, 1, 0, 0};
      tbl[6] = '{2'd2, 15'h0100, 15'h0101, 16'h0000, 1, 0, {8{32'hBBBB_CCCC}}, {8{32'h0BAD_F00D}},
                 0, 0, 0, 1, 0};
      tbl[7] = '{2'd2, 15'h0700, 15'h0701, 16'h1000, 1, 1, {8{32'h1234_5678}}, {8{32'h8765_4321}},
                 1, 3, 1, 1, 1};
      tbl[8] = '{2'd2, 15'h0200, 15'h0200, 16'h0001, 1, 0, {8{32'h0F0F_0F0F}}, {8{32'hF0F0_F0F0}},
                 2, 1, 1, Byp ? 0 : 1, 0};
      tbl[9] = '{2'd1, 15'h0042, 15'h0043, 16'hFFFF, 0, 0, {8{32'h4242_4242}}, '0,
                 0, 0, 0, 0, 0};

      i_nrst = 1'b0;
      i_saveAdr = '0; i_loadAdr = '0; i_exportedBGBlock = '0; i_needLoad = 1'b0;
      i_memReadData = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      i_nrst = 1'b1;
      bad = 0; any_valid = 0;
      repeat (10) begin
         @(negedge clk);
         #1;
         if ({o_flushDone, o_flushClearMask, o_pausePipeline, o_importBGBlockSingleClock,
              o_importedBGBlock, o_memCmdValid, o_memCmdWrite, o_memAdr, o_memWriteData,
              o_memWriteMask, o_saveCount, o_loadCount, o_errOverrun} !== '0) bad = 1;
         if (o_memCmdValid) any_valid = 1;
      end
      chk("reset_outputs_zero", bad, 1'b0);
      chk("reset_no_cmd", any_valid, 1'b0);

      for (int i = 0; i < 10; i++) run_event(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         rv.trans = 2'($urandom_range(0, 3));
         rv.sa    = ADR_W'($urandom);
         rv.la    = ($urandom_range(0, 3) == 0) ? rv.sa : ADR_W'($urandom);
         rv.msk   = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
         rv.need  = 1'($urandom);
         rv.flush = ($urandom_range(0, 3) == 0);
         rv.blk   = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
         rv.rdata = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
         rv.rdy   = $urandom_range(0, 3);
         rv.lat   = $urandom_range(0, 4);
         rv = model(rv);
         run_event(rv, $sformatf("rnd%0d", i));
      end
      chk("no_overrun_in_normal_use", o_errOverrun, 1'b0);

      // Transition arriving while waiting for read data.
      @(negedge clk);
      i_PixelBlockTransition = 2'd2; i_saveAdr = 15'h0050; i_loadAdr = 15'h0051;
      i_exportedMSKBGBlock = 16'h0; i_needLoad = 1'b1;
      @(negedge clk);
      idle_inputs();
      i_memCmdReady = 1'b1;
      @(negedge clk);
      idle_inputs();
      i_PixelBlockTransition = 2'd2; i_exportedMSKBGBlock = 16'hFFFF;
      @(negedge clk);
      idle_inputs();
      #1 chk("overrun_set", o_errOverrun, 1'b1);
      @(negedge clk);
      i_memReadValid = 1'b1; i_memReadData = {8{32'h600D_D00D}};
      #1 chk("overrun_import_still_done", o_importBGBlockSingleClock, 1'b1);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         idle_inputs();
         #1 if (o_memCmdValid) bad = 1;
      end
      chk("overrun_event_ignored", bad, 1'b0);
      chk("overrun_sticky", o_errOverrun, 1'b1);

      // Asynchronous reset while a save waits for ready.
      @(negedge clk);
      i_PixelBlockTransition = 2'd2; i_saveAdr = 15'h0060; i_loadAdr = 15'h0061;
      i_exportedMSKBGBlock = 16'h0F00; i_needLoad = 1'b1; i_flushReq = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1 chk("rst_pre_valid", o_memCmdValid, 1'b1);
      #2 i_nrst = 1'b0;
      #1;
      chk("rst_valid_drops", o_memCmdValid, 1'b0);
      chk("rst_pause_drops", o_pausePipeline, 1'b0);
      chk("rst_err_cleared", o_errOverrun, 1'b0);
      chk("rst_counts_cleared", {o_saveCount, o_loadCount}, '0);
      @(negedge clk);
      i_nrst = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         #1 if (o_memCmdValid || o_pausePipeline || o_flushDone) bad = 1;
      end
      chk("rst_stays_idle", bad, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
